mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- EXE-stage controller that feeds the team's 2-stage Booth/Wallace 32x32 multiplier and returns 32-bit results in order, with a valid/ready handshake and tags.
- The multiplier cannot stall. Its operands and signedness are sampled combinationally in cycle N, and its 64-bit product is valid in cycle N+1.
- This block therefore issues only when result space is guaranteed, selects the low or high product half, buffers results in a small FIFO, and supports pipeline flush (exception/ertn).

Parameters:
- TAG_W, 5, width of the pass-through tag (destination register id).
- RES_DEPTH, 2, result FIFO entries; minimum 2; power of two.

Ports:
- mul_clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  EXE presents a multiply op
- req_ready  out  1  controller accepts the op this cycle
- req_op  in  2  00 MUL_W (low), 01 MULH_W (signed high), 10 MULH_WU (unsigned high), 11 reserved
- req_src1  in  32  multiplicand
- req_src2  in  32  multiplier
- req_tag  in  TAG_W  tag returned with the result
- flush  in  1  kill all in-flight and buffered ops
- mul_x  out  32  multiplier operand x
- mul_y  out  32  multiplier operand y
- mul_signed  out  1  multiplier signed-mode select
- mul_result  in  64  multiplier product, one cycle after issue
- rsp_valid  out  1  result available
- rsp_ready  in  1  MEM stage takes the result
- rsp_data  out  32  selected product half
- rsp_tag  out  TAG_W  tag of rsp_data
- busy  out  1  any op in flight or buffered

Behaviour:
- Reset (resetn low, asynchronous): clears s1_valid, FIFO count, read/write pointers and the warm flag.
  - Outputs during reset: req_ready=0, rsp_valid=0, busy=0, mul_x=0, mul_y=0, mul_signed=0.
  - rsp_data and rsp_tag read 0 when the FIFO is empty.
- Warm-up: the warm flag sets on the first mul_clk edge after resetn rises. req_ready=0 until it is set, because the multiplier forces its result to 0 in that window.
- Issue condition: req_ready = warm & ~flush & (count + s1_valid - rsp_fire) < RES_DEPTH, where rsp_fire = rsp_valid & rsp_ready.
  - This creates a combinational path rsp_ready -> req_ready; that path is required.
- Fire: issue_fire = req_valid & req_ready.
  - When issue_fire=1: mul_x=req_src1, mul_y=req_src2, mul_signed=(req_op==01).
  - Otherwise mul_x, mul_y and mul_signed are all 0.
  - MUL_W uses mul_signed=0; the low 32 bits are identical in both modes.
- Stage-1 register (updated at the edge ending cycle N): s1_valid<=issue_fire, s1_hi<=(req_op==01 | req_op==10), s1_rsv<=(req_op==11), s1_tag<=req_tag.
- Capture (cycle N+1, if s1_valid): write to the FIFO at wptr.
  - Data: s1_rsv ? 0 : (s1_hi ? mul_result[63:32] : mul_result[31:0]).
  - Tag: s1_tag.
  - The write takes effect at the edge ending N+1.
- Latency: accept in cycle N gives rsp_valid in cycle N+2 at the earliest. There is no bypass. Sustained throughput is 1 op/cycle while rsp_ready=1.
- FIFO:
  - rsp_valid = (count!=0) & ~flush. Head entry drives rsp_data and rsp_tag.
  - Pointers wrap modulo RES_DEPTH.
  - Simultaneous write and read: count unchanged, both pointers advance.
  - Overflow cannot occur by construction. The bench asserts count <= RES_DEPTH.
- Flush (synchronous, one cycle): at the edge, s1_valid<=0, count<=0, rptr<=wptr<=0.
  - In the flush cycle, req_ready=0 and rsp_valid=0, so no handshake completes.
  - The product returning in the cycle after flush is discarded because s1_valid=0.
- busy = s1_valid | (count!=0).
- Reset mid-operation: all state is lost immediately. No response is produced for ops accepted before reset.

Decomposition:
- Package mul_ctrl_pkg holds:
  - the op encodings OP_MUL_W, OP_MULH_W, OP_MULH_WU, OP_RSV;
  - RES_DEPTH_MIN=2.
- One sub-module: mul_res_fifo, a parameterised (RES_DEPTH, width 32+TAG_W) circular buffer with count, sync clear and async reset.
- The issue/credit logic and stage-1 register stay in mul_issue_ctrl.

Test Plan:
- Reset and warm-up: hold resetn=0, then release -> all outputs 0; req_ready=0 in the first cycle after release and 1 from the next cycle.
- MUL_W with src1=0xFFFFFFFF, src2=0x00000002, tag=3, accepted in cycle N -> in cycle N+1, mul_signed=0 was driven and mul_result=0x00000001_FFFFFFFE; in cycle N+2, rsp_valid=1, rsp_data=0xFFFFFFFE, rsp_tag=3.
- MULH_W with 0xFFFFFFFF * 0x00000002 -> rsp_data=0xFFFFFFFF. MULH_WU with the same operands -> rsp_data=0x00000001. Reserved op -> rsp_data=0.
- Backpressure: rsp_ready=0 and 3 back-to-back requests -> 2 accepted, then req_ready=0 and busy=1. Raising rsp_ready -> results delivered in order, and the third request is accepted in the same cycle as the first dequeue.
- Flush with one op buffered and one in stage 1 -> rsp_valid=0 in the flush cycle. The next cycle shows count=0, busy=0 and no response for either op. A new op then completes normally.
- Asynchronous reset asserted mid-cycle with two ops in flight -> rsp_valid, busy and req_ready go to 0 immediately. After the warm-up cycle, no stale response appears.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared op encodings and sizing limits for the multiplier issue controller.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MUL_W   = 2'b00,
    OP_MULH_W  = 2'b01,
    OP_MULH_WU = 2'b10,
    OP_RSV     = 2'b11
  } mul_op_e;

  localparam int RES_DEPTH_MIN = 2;

  function automatic logic op_is_hi(input logic [1:0] op);
    return (op == OP_MULH_W) || (op == OP_MULH_WU);
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Request/response handshake between EXE, the multiply controller and MEM.
interface mul_issue_ctrl_if #(
  parameter int TAG_W = 5
) ();

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_src1;
  logic [31:0]      req_src2;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_src1, req_src2, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready
  );

endinterface

// File: rtl/mul_res_fifo.sv
// Circular result buffer with occupancy count; clr empties it in one cycle.
// Head reads as zero when empty; writer must never exceed DEPTH entries.
module mul_res_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                       mul_clk,
  input  logic                       resetn,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge mul_clk) begin
    if (wr_en && !clr) mem[wptr] <= wr_dat;
  end

  assign rd_dat = (count == '0) ? '0 : mem[rptr];

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issues ops to a non-stalling 2-cycle multiplier only when result space is reserved;
// accept in cycle N yields rsp_valid no earlier than N+2, results returned in order.
module mul_issue_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int TAG_W     = 5,
  parameter int RES_DEPTH = 2
) (
  input  logic                 mul_clk,
  input  logic                 resetn,
  mul_issue_ctrl_if.slave      io,
  input  logic                 flush,
  output logic [31:0]          mul_x,
  output logic [31:0]          mul_y,
  output logic                 mul_signed,
  input  logic [63:0]          mul_result,
  output logic                 busy
);

  localparam int CNT_W = $clog2(RES_DEPTH) + 1;

  logic             warm;
  logic             s1_valid;
  logic             s1_hi;
  logic             s1_rsv;
  logic [TAG_W-1:0] s1_tag;

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ;
  logic             req_ready;
  logic             rsp_valid;
  logic             rsp_fire;
  logic             issue_fire;
  logic [31:0]      cap_data;
  logic [TAG_W+31:0] head;

  // Slots already owed: buffered results plus the product landing next cycle.
  assign rsp_fire   = rsp_valid & io.rsp_ready;
  assign occ        = {1'b0, count} + (CNT_W+1)'(s1_valid) - (CNT_W+1)'(rsp_fire);
  assign req_ready  = warm & ~flush & (occ < (CNT_W+1)'(RES_DEPTH));
  assign issue_fire = io.req_valid & req_ready;

  assign io.req_ready = req_ready;

  assign mul_x      = issue_fire ? io.req_src1 : 32'h0;
  assign mul_y      = issue_fire ? io.req_src2 : 32'h0;
  assign mul_signed = issue_fire & (io.req_op == OP_MULH_W);

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      warm <= 1'b0;
    end else begin
      warm <= 1'b1;
    end
  end

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_hi    <= 1'b0;
      s1_rsv   <= 1'b0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= issue_fire;
      s1_hi    <= op_is_hi(io.req_op);
      s1_rsv   <= (io.req_op == OP_RSV);
      s1_tag   <= io.req_tag;
    end
  end

  assign cap_data = s1_rsv ? 32'h0 : (s1_hi ? mul_result[63:32] : mul_result[31:0]);

  mul_res_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (TAG_W + 32)
  ) u_fifo (
    .mul_clk (mul_clk),
    .resetn  (resetn),
    .clr     (flush),
    .wr_en   (s1_valid),
    .wr_dat  ({s1_tag, cap_data}),
    .rd_en   (rsp_fire),
    .rd_dat  (head),
    .count   (count)
  );

  assign rsp_valid    = (count != '0) & ~flush;
  assign io.rsp_valid = rsp_valid;
  assign io.rsp_data  = head[31:0];
  assign io.rsp_tag   = head[TAG_W+31:32];

  assign busy = s1_valid | (count != '0);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed vector table plus hand-written backpressure, flush and async-reset sequences.
module tb_mul_issue_ctrl;
  import mul_ctrl_pkg::*;

  localparam int TAG_W     = 5;
  localparam int RES_DEPTH = 2;

  logic        mul_clk = 1'b0;
  logic        resetn  = 1'b0;
  logic        flush   = 1'b0;
  logic [31:0] mul_x, mul_y;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  mul_issue_ctrl #(.TAG_W(TAG_W), .RES_DEPTH(RES_DEPTH)) dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .io         (bus),
    .flush      (flush),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .busy       (busy)
  );

  always #5 mul_clk = ~mul_clk;

  // Behavioural multiplier: product of the sampled operands appears next cycle.
  function automatic logic [63:0] mult(input logic [31:0] x, input logic [31:0] y, input logic sg);
    logic [63:0] a, b;
    a = sg ? {{32{x[31]}}, x} : {32'h0, x};
    b = sg ? {{32{y[31]}}, y} : {32'h0, y};
    return a * b;
  endfunction

  always @(posedge mul_clk or negedge resetn) begin
    if (!resetn) mul_result <= 64'h0;
    else         mul_result <= mult(mul_x, mul_y, mul_signed);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge mul_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    bus.req_tag   = tag;
  endtask

  always @(negedge mul_clk) begin
    if (resetn) begin
      n_cmp++;
      if (int'(dut.u_fifo.count) > RES_DEPTH) begin
        n_err++;
        $display("FAIL fifo_count_bound: got %0d limit %0d", dut.u_fifo.count, RES_DEPTH);
      end
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  tag;
    logic        sgn;
    logic [63:0] prod;
    logic [31:0] data;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{OP_MUL_W,   32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  1'b0, 64'h0000_0001_FFFF_FFFE, 32'hFFFF_FFFE};
    vt[1] = '{OP_MULH_W,  32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFF};
    vt[2] = '{OP_MULH_WU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5,  1'b0, 64'h0000_0001_FFFF_FFFE, 32'h0000_0001};
    vt[3] = '{OP_RSV,     32'hFFFF_FFFF, 32'h0000_0002, 5'd6,  1'b0, 64'h0000_0001_FFFF_FFFE, 32'h0000_0000};
    vt[4] = '{OP_MUL_W,   32'h1234_5678, 32'h0000_0010, 5'd7,  1'b0, 64'h0000_0001_2345_6780, 32'h2345_6780};
    vt[5] = '{OP_MULH_W,  32'h8000_0000, 32'h8000_0000, 5'd8,  1'b1, 64'h4000_0000_0000_0000, 32'h4000_0000};
    vt[6] = '{OP_MULH_WU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b0, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE};
    vt[7] = '{OP_MULH_W,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  1'b1, 64'h0000_0000_0000_0001, 32'h0000_0000};

    // Reset state, with a request presented to prove nothing leaks to the multiplier.
    drive(1'b1, OP_MULH_W, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9);
    bus.rsp_ready = 1'b1;
    @(negedge mul_clk);
    chk("rst_req_ready",  bus.req_ready,  0);
    chk("rst_rsp_valid",  bus.rsp_valid,  0);
    chk("rst_busy",       busy,           0);
    chk("rst_mul_x",      mul_x,          0);
    chk("rst_mul_y",      mul_y,          0);
    chk("rst_mul_signed", mul_signed,     0);
    chk("rst_rsp_data",   bus.rsp_data,   0);
    chk("rst_rsp_tag",    bus.rsp_tag,    0);
    drive(1'b0, OP_MUL_W, 32'h0, 32'h0, 5'd0);
    step();
    resetn = 1'b1;
    @(negedge mul_clk);
    chk("warm_first_cycle_ready", bus.req_ready, 0);
    step();
    @(negedge mul_clk);
    chk("warm_second_cycle_ready", bus.req_ready, 1);
    step();

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vt[i].op, vt[i].s1, vt[i].s2, vt[i].tag);
      @(negedge mul_clk);
      chk($sformatf("v%0d_req_ready", i), bus.req_ready, 1);
      chk($sformatf("v%0d_mul_signed", i), mul_signed, vt[i].sgn);
      chk($sformatf("v%0d_mul_x", i), mul_x, vt[i].s1);
      step();
      drive(1'b0, OP_MUL_W, 32'h0, 32'h0, 5'd0);
      @(negedge mul_clk);
      chk($sformatf("v%0d_product", i), mul_result, vt[i].prod);
      chk($sformatf("v%0d_no_bypass", i), bus.rsp_valid, 0);
      chk($sformatf("v%0d_busy_s1", i), busy, 1);
      step();
      @(negedge mul_clk);
      chk($sformatf("v%0d_rsp_valid", i), bus.rsp_valid, 1);
      chk($sformatf("v%0d_rsp_data", i), bus.rsp_data, vt[i].data);
      chk($sformatf("v%0d_rsp_tag", i), bus.rsp_tag, vt[i].tag);
      step();
    end

    // Backpressure: two slots, third request waits for the first dequeue.
    bus.rsp_ready = 1'b0;
    drive(1'b1, OP_MUL_W, 32'h100, 32'h2, 5'd10);
    @(negedge mul_clk);
    chk("bp_acc0", bus.req_ready, 1);
    step();
    drive(1'b1, OP_MUL_W, 32'h200, 32'h2, 5'd11);
    @(negedge mul_clk);
    chk("bp_acc1", bus.req_ready, 1);
    step();
    drive(1'b1, OP_MUL_W, 32'h300, 32'h2, 5'd12);
    @(negedge mul_clk);
    chk("bp_full_ready", bus.req_ready, 0);
    chk("bp_full_busy", busy, 1);
    step();
    @(negedge mul_clk);
    chk("bp_hold_ready", bus.req_ready, 0);
    chk("bp_hold_rsp_valid", bus.rsp_valid, 1);
    step();
    bus.rsp_ready = 1'b1;
    @(negedge mul_clk);
    chk("bp_accept_on_dequeue", bus.req_ready, 1);
    chk("bp_r0_tag", bus.rsp_tag, 10);
    chk("bp_r0_data", bus.rsp_data, 32'h200);
    step();
    drive(1'b0, OP_MUL_W, 32'h0, 32'h0, 5'd0);
    @(negedge mul_clk);
    chk("bp_r1_valid", bus.rsp_valid, 1);
    chk("bp_r1_tag", bus.rsp_tag, 11);
    chk("bp_r1_data", bus.rsp_data, 32'h400);
    step();
    @(negedge mul_clk);
    chk("bp_r2_valid", bus.rsp_valid, 1);
    chk("bp_r2_tag", bus.rsp_tag, 12);
    chk("bp_r2_data", bus.rsp_data, 32'h600);
    step();
    @(negedge mul_clk);
    chk("bp_drained_valid", bus.rsp_valid, 0);
    chk("bp_drained_busy", busy, 0);
    step();

    // Flush with one op buffered and one in stage 1.
    bus.rsp_ready = 1'b0;
    drive(1'b1, OP_MUL_W, 32'h7, 32'h3, 5'd5);
    @(negedge mul_clk);
    chk("fl_accA", bus.req_ready, 1);
    step();
    drive(1'b1, OP_MUL_W, 32'h9, 32'h3, 5'd6);
    @(negedge mul_clk);
    chk("fl_accB", bus.req_ready, 1);
    step();
    drive(1'b0, OP_MUL_W, 32'h0, 32'h0, 5'd0);
    flush = 1'b1;
    @(negedge mul_clk);
    chk("fl_cycle_rsp_valid", bus.rsp_valid, 0);
    chk("fl_cycle_req_ready", bus.req_ready, 0);
    step();
    flush = 1'b0;
    @(negedge mul_clk);
    chk("fl_after_busy", busy, 0);
    chk("fl_after_count", dut.u_fifo.count, 0);
    chk("fl_after_rsp_valid", bus.rsp_valid, 0);
    step();
    @(negedge mul_clk);
    chk("fl_after2_rsp_valid", bus.rsp_valid, 0);
    step();
    bus.rsp_ready = 1'b1;
    drive(1'b1, OP_MULH_WU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    @(negedge mul_clk);
    chk("fl_new_ready", bus.req_ready, 1);
    step();
    drive(1'b0, OP_MUL_W, 32'h0, 32'h0, 5'd0);
    @(negedge mul_clk);
    chk("fl_new_no_bypass", bus.rsp_valid, 0);
    step();
    @(negedge mul_clk);
    chk("fl_new_rsp_valid", bus.rsp_valid, 1);
    chk("fl_new_rsp_data", bus.rsp_data, 32'hFFFF_FFFE);
    chk("fl_new_rsp_tag", bus.rsp_tag, 9);
    step();

    // Asynchronous reset mid-cycle with two ops in flight.
    bus.rsp_ready = 1'b0;
    drive(1'b1, OP_MUL_W, 32'h11, 32'h2, 5'd1);
    step();
    drive(1'b1, OP_MUL_W, 32'h22, 32'h2, 5'd2);
    step();
    drive(1'b0, OP_MUL_W, 32'h0, 32'h0, 5'd0);
    @(negedge mul_clk);
    chk("ar_pre_busy", busy, 1);
    chk("ar_pre_rsp_valid", bus.rsp_valid, 1);
    @(posedge mul_clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("ar_rsp_valid", bus.rsp_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_req_ready", bus.req_ready, 0);
    step();
    resetn = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge mul_clk);
    chk("ar_warm_ready", bus.req_ready, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge mul_clk);
      chk($sformatf("ar_stale_valid_%0d", c), bus.rsp_valid, 0);
      chk($sformatf("ar_stale_busy_%0d", c), busy, 0);
      chk($sformatf("ar_ready_%0d", c), bus.req_ready, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
